// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port round-robin front end for an SDRAM driver
// Holds off new grants ahead of each refresh and bounds every driver handshake with a timeout.
module sdram_port_arbiter #(
    parameter int REFRESH_INTERVAL = 1116,
    parameter int GUARD            = 32,
    parameter int TIMEOUT          = 255
) (
    input  logic        SDRAM_CLK_IN,
    input  logic        reset,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_we,
    input  logic        b_we,
    input  logic [12:0] a_addr,
    input  logic [12:0] b_addr,
    input  logic [1:0]  a_bank,
    input  logic [1:0]  b_bank,
    output logic        a_grant,
    output logic        b_grant,
    output logic        a_done,
    output logic        b_done,
    output logic        start_write,
    output logic        start_read,
    output logic [12:0] ADDR,
    output logic [1:0]  BANK,
    input  logic        process_flg,
    output logic        refresh_due,
    output logic        timeout_err
);

    localparam int RW = $clog2(REFRESH_INTERVAL) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_IDLE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;      // 1 = port B owns the transaction
    logic          we_q, we_d;
    logic [12:0]   addr_q, addr_d;
    logic [1:0]    bank_q, bank_d;
    logic          last_b_q, last_b_d;    // 1 = port B was served last
    logic          a_done_q, a_done_d;
    logic          b_done_q, b_done_d;
    logic [RW-1:0] ref_q, ref_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    logic          a_win, b_win, finish, tmo_hit, strobe_on;
    logic [TW-1:0] tmo_inc;

    assign refresh_due = (ref_q >= RW'(REFRESH_INTERVAL - GUARD));
    assign a_win       = a_req & (~b_req | last_b_q);
    assign b_win       = b_req & ~a_win;
    assign tmo_inc     = tmo_q + TW'(1);
    assign tmo_hit     = (tmo_inc == TW'(TIMEOUT));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        bank_d   = bank_q;
        last_b_d = last_b_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        a_done_d = 1'b0;
        b_done_d = 1'b0;
        finish   = 1'b0;
        ref_d    = (ref_q == RW'(REFRESH_INTERVAL - 1)) ? '0 : ref_q + RW'(1);

        case (state_q)
            S_IDLE: begin
                if ((a_req || b_req) && !process_flg && !refresh_due) begin
                    state_d = S_ISSUE;
                    owner_d = b_win;
                    we_d    = b_win ? b_we   : a_we;
                    addr_d  = b_win ? b_addr : a_addr;
                    bank_d  = b_win ? b_bank : a_bank;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
                tmo_d   = '0;
            end
            S_WAIT_BUSY: begin
                if (process_flg) begin
                    state_d = S_WAIT_IDLE;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_WAIT_IDLE: begin
                if (!process_flg) begin
                    finish = 1'b1;
                end else if (tmo_hit) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Normal completion and timeout abort both release the owner the same way.
        if (finish) begin
            state_d  = S_IDLE;
            tmo_d    = '0;
            a_done_d = ~owner_q;
            b_done_d = owner_q;
            last_b_d = owner_q;
        end
    end

    always_ff @(posedge SDRAM_CLK_IN) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            bank_q   <= '0;
            last_b_q <= 1'b1;
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
            ref_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
            last_b_q <= last_b_d;
            a_done_q <= a_done_d;
            b_done_q <= b_done_d;
            ref_q    <= ref_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    // Strobe stays low until the driver acknowledges, so a slower driver clock cannot miss it.
    assign strobe_on   = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY);
    assign start_write = ~(strobe_on & we_q);
    assign start_read  = ~(strobe_on & ~we_q);
    assign a_grant     = (state_q == S_ISSUE) & ~owner_q;
    assign b_grant     = (state_q == S_ISSUE) & owner_q;
    assign a_done      = a_done_q;
    assign b_done      = b_done_q;
    assign ADDR        = addr_q;
    assign BANK        = bank_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    localparam int RI = 64;
    localparam int GD = 8;
    localparam int TO = 16;
    localparam int NR = 10;

    typedef struct packed {
        logic        id;
        logic        we;
        logic [12:0] addr;
        logic [1:0]  bank;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req, a_we, b_we;
    logic [12:0] a_addr, b_addr;
    logic [1:0]  a_bank, b_bank;
    logic        a_grant, b_grant, a_done, b_done;
    logic        start_write, start_read;
    logic [12:0] ADDR;
    logic [1:0]  BANK;
    logic        process_flg;
    logic        refresh_due, timeout_err;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .REFRESH_INTERVAL(RI),
        .GUARD(GD),
        .TIMEOUT(TO)
    ) dut (
        .SDRAM_CLK_IN(clk),
        .reset(reset),
        .a_req(a_req),
        .b_req(b_req),
        .a_we(a_we),
        .b_we(b_we),
        .a_addr(a_addr),
        .b_addr(b_addr),
        .a_bank(a_bank),
        .b_bank(b_bank),
        .a_grant(a_grant),
        .b_grant(b_grant),
        .a_done(a_done),
        .b_done(b_done),
        .start_write(start_write),
        .start_read(start_read),
        .ADDR(ADDR),
        .BANK(BANK),
        .process_flg(process_flg),
        .refresh_due(refresh_due),
        .timeout_err(timeout_err)
    );

    int   cyc = 0;
    int   rc  = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    txn_t exp_q[$];
    txn_t arr[2][NR];
    int   gcnt[2] = '{0, 0};
    int   dcnt[2] = '{0, 0};
    int   gcyc[2] = '{0, 0};
    int   dcyc[2] = '{0, 0};
    int   grant_rc = 0, low_len = 0, last_low = 0;
    bit   drv_en = 1'b1, drv_rand = 1'b0;
    int   rise_dly = 1, busy_len = 3, rise_cyc = 0, drop_cyc = 0;

    // Expected refresh count: wraps every RI cycles, restarts on reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) rc <= 0;
        else       rc <= (rc == RI - 1) ? 0 : rc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic txn_t rnd_txn(input int id);
        txn_t t;
        t.id   = 1'(id);
        t.we   = 1'($urandom_range(0, 1));
        t.addr = 13'($urandom);
        t.bank = 2'($urandom);
        return t;
    endfunction

    task automatic set_port(input int id, input logic req, input txn_t t);
        if (id == 0) begin
            a_req = req; a_we = t.we; a_addr = t.addr; a_bank = t.bank;
        end else begin
            b_req = req; b_we = t.we; b_addr = t.addr; b_bank = t.bank;
        end
    endtask

    task automatic issue(input txn_t t);
        exp_q.push_back(t);
        set_port(int'(t.id), 1'b1, t);
    endtask

    task automatic wait_grant(input int id, input int budget);
        int old = gcnt[id];
        int n = 0;
        while (gcnt[id] == old && n < budget) begin
            @(negedge clk); #2; n++;
        end
        chk($sformatf("grant_wait_%0d", id), 32'(gcnt[id] > old), 32'd1);
    endtask

    task automatic wait_done(input int id, input int budget);
        int old = dcnt[id];
        int n = 0;
        while (dcnt[id] == old && n < budget) begin
            @(negedge clk); #2; n++;
        end
        chk($sformatf("done_wait_%0d", id), 32'(dcnt[id] > old), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input int budget);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (process_flg !== lvl && n < budget);
        chk("busy_wait", 32'(process_flg), 32'(lvl));
    endtask

    task automatic wait_quiet();
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(process_flg == 1'b0 && start_write && start_read && rc >= 2 && rc < 20) && n < 300);
        chk("quiet_wait", 32'(n < 300), 32'd1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_a_grant"}, 32'(a_grant), 32'd0);
        chk({p, "_b_grant"}, 32'(b_grant), 32'd0);
        chk({p, "_a_done"}, 32'(a_done), 32'd0);
        chk({p, "_b_done"}, 32'(b_done), 32'd0);
        chk({p, "_strobes"}, 32'({start_write, start_read}), 32'd3);
        chk({p, "_addr"}, 32'(ADDR), 32'd0);
        chk({p, "_bank"}, 32'(BANK), 32'd0);
        chk({p, "_refresh_due"}, 32'(refresh_due), 32'd0);
        chk({p, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic req_proc(input int id);
        for (int i = 0; i < NR; i++) begin
            @(posedge clk); #1;
            set_port(id, 1'b1, arr[id][i]);
            wait_grant(id, 2000);
            @(posedge clk); #1;
            set_port(id, 1'b0, rnd_txn(id));
            wait_done(id, 2000);
        end
    endtask

    // Monitor: pops the scoreboard on every grant and checks per-cycle invariants.
    initial begin : monitor
        bit   rst_s, outstanding, own, prev_low, low;
        int   low_start, rc_prev;
        txn_t lat, e;
        outstanding = 0; own = 0; prev_low = 0; low_start = 0; rc_prev = 0; lat = '0;
        forever begin
            @(posedge clk);
            rst_s = reset;
            @(negedge clk);
            if (rst_s) begin
                outstanding = 0; prev_low = 0; rc_prev = 0;
            end else begin
                chk("strobe_excl", 32'(start_write | start_read), 32'd1);
                chk("refresh_due", 32'(refresh_due), 32'(rc >= RI - GD));
                low = !start_write || !start_read;
                if (low && !prev_low) low_start = cyc;
                if (!low && prev_low) begin
                    low_len  = cyc - low_start;
                    last_low = cyc - 1;
                end
                prev_low = low;
                if (outstanding) begin
                    chk("addr_stable", 32'(ADDR), 32'(lat.addr));
                    chk("bank_stable", 32'(BANK), 32'(lat.bank));
                end
                if (a_done || b_done) begin
                    chk("done_excl", 32'(a_done && b_done), 32'd0);
                    chk("done_outstanding", 32'(outstanding), 32'd1);
                    chk("done_id", 32'(b_done), 32'(own));
                    outstanding = 0;
                    dcnt[b_done]++;
                    dcyc[b_done] = cyc;
                end
                if (a_grant || b_grant) begin
                    chk("grant_excl", 32'(a_grant && b_grant), 32'd0);
                    chk("grant_vs_done", 32'(a_done || b_done), 32'd0);
                    chk("grant_overlap", 32'(outstanding), 32'd0);
                    chk("grant_gate", 32'(rc_prev < RI - GD), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL grant_unexpected: got grant b=%0d, want none (cycle %0d)", b_grant, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_id", 32'(b_grant), 32'(e.id));
                        chk("grant_addr", 32'(ADDR), 32'(e.addr));
                        chk("grant_bank", 32'(BANK), 32'(e.bank));
                        chk("grant_strobe", 32'({start_write, start_read}), e.we ? 32'd1 : 32'd2);
                        lat = e;
                    end
                    own = b_grant;
                    outstanding = 1;
                    gcnt[b_grant]++;
                    gcyc[b_grant] = cyc;
                    grant_rc = rc;
                end
                rc_prev = rc;
            end
        end
    end

    // Driver model: acknowledges a low strobe after a delay, stays busy, then goes idle.
    initial begin : driver
        int d, bl;
        process_flg = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (drv_en && (!start_write || !start_read)) begin
                d  = drv_rand ? int'($urandom_range(0, 4)) : rise_dly;
                bl = drv_rand ? int'($urandom_range(1, 8)) : busy_len;
                repeat (d) begin @(posedge clk); #1; end
                process_flg = 1'b1;
                rise_cyc = cyc;
                repeat (bl) begin @(posedge clk); #1; end
                process_flg = 1'b0;
                drop_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        txn_t t;
        int   k, g, old, n;
        reset = 1'b1;
        set_port(0, 1'b0, '0);
        set_port(1, 1'b0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk); #1 reset = 1'b0;

        // Single write from A with a fixed driver profile.
        wait_quiet();
        rise_dly = 2; busy_len = 5;
        t = '{id: 1'b0, we: 1'b1, addr: 13'h155, bank: 2'd2};
        issue(t);
        k = cyc;
        wait_grant(0, 50);
        chk("single_latency", 32'(gcyc[0]), 32'(k + 1));
        @(posedge clk); #1 set_port(0, 1'b0, rnd_txn(0));
        wait_done(0, 100);
        chk("single_strobe_end", 32'(last_low), 32'(rise_cyc));
        chk("single_done_cyc", 32'(dcyc[0]), 32'(drop_cyc + 1));

        // Driver never answers: read from B must time out.
        chk("err_before", 32'(timeout_err), 32'd0);
        wait_quiet();
        drv_en = 1'b0;
        t = rnd_txn(1); t.we = 1'b0;
        issue(t);
        wait_grant(1, 50);
        g = gcyc[1];
        @(posedge clk); #1 set_port(1, 1'b0, rnd_txn(1));
        wait_done(1, 100);
        chk("tmo_strobe_len", 32'(low_len), 32'(TO + 1));
        chk("tmo_done_cyc", 32'(dcyc[1]), 32'(g + TO + 1));
        chk("tmo_err_set", 32'(timeout_err), 32'd1);
        drv_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("tmo_err_sticky", 32'(timeout_err), 32'd1);

        // Request raised inside the refresh hold-off window.
        rise_dly = 1; busy_len = 3;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (rc != RI - GD + 1 && n < 200);
        issue(rnd_txn(0));
        wait_grant(0, 100);
        chk("refresh_grant_rc", 32'(grant_rc), 32'd1);
        @(posedge clk); #1 set_port(0, 1'b0, rnd_txn(0));
        wait_done(0, 100);

        // B pulses its request for one cycle while A is busy.
        wait_quiet();
        busy_len = 8;
        issue(rnd_txn(0));
        wait_grant(0, 50);
        @(posedge clk); #1 set_port(0, 1'b0, rnd_txn(0));
        wait_busy(1'b1, 50);
        old = gcnt[1];
        set_port(1, 1'b1, rnd_txn(1));
        @(posedge clk); #1 set_port(1, 1'b0, rnd_txn(1));
        wait_done(0, 100);
        repeat (20) @(negedge clk);
        chk("withdraw_no_grant", 32'(gcnt[1]), 32'(old));
        chk("withdraw_queue", 32'(exp_q.size()), 32'd0);

        // Reset while the transaction sits in WAIT_IDLE.
        chk("err_still_set", 32'(timeout_err), 32'd1);
        wait_quiet();
        busy_len = 10;
        issue(rnd_txn(0));
        wait_grant(0, 50);
        @(posedge clk); #1 set_port(0, 1'b0, rnd_txn(0));
        wait_busy(1'b1, 50);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        old = dcnt[0];
        wait_busy(1'b0, 50);
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 32'(dcnt[0]), 32'(old));

        // Both ports contend from reset: service must alternate starting with A.
        drv_rand = 1'b1;
        for (int i = 0; i < NR; i++) begin
            arr[0][i] = rnd_txn(0);
            arr[1][i] = rnd_txn(1);
            exp_q.push_back(arr[0][i]);
            exp_q.push_back(arr[1][i]);
        end
        old = dcnt[0] + dcnt[1];
        fork
            req_proc(0);
            req_proc(1);
        join
        repeat (10) @(negedge clk);
        chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_done_total", 32'(dcnt[0] + dcnt[1]), 32'(old + 2 * NR));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 1116, meaning the refresh period in clock cycles (64 ms / 8192 / 7 ns).
REQ-002 SHALL have parameter GUARD, default 32, meaning the cycles before each refresh during which no new grant is issued.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait on each driver handshake phase.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SDRAM_CLK_IN  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous reset, active-high.
REQ-007 a_req, b_req  input  1 each  requester access request, level.
REQ-008 a_we, b_we  input  1 each  1 = write, 0 = read.
REQ-009 a_addr, b_addr  input  13 each  row address.
REQ-010 a_bank, b_bank  input  2 each  bank select.
REQ-011 a_grant, b_grant  output  1 each  one-cycle grant pulse.
REQ-012 a_done, b_done  output  1 each  one-cycle completion pulse.
REQ-013 start_write, start_read  output  1 each  active-low start strobes to the SDRAM driver.
REQ-014 ADDR  output  13  row address to the driver.
REQ-015 BANK  output  2  bank select to the driver.
REQ-016 process_flg  input  1  driver busy flag, 1 = busy.
REQ-017 refresh_due  output  1  grant hold-off window active.
REQ-018 timeout_err  output  1  sticky handshake-timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY and WAIT_IDLE; a one-hot or binary encoding is allowed.
REQ-020 IDLE SHALL go to ISSUE when (a_req or b_req) and process_flg=0 and refresh_due=0; otherwise it SHALL stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: a sole requester wins; when both request, the requester not served last wins; last_served resets to B, so A wins the first tie.
REQ-022 In IDLE, on the transition to ISSUE, the block SHALL latch the winner's id, we, addr and bank.
REQ-023 ADDR and BANK SHALL be driven from the latched values and SHALL stay stable from ISSUE until the done pulse.
REQ-024 ISSUE SHALL last exactly 1 cycle: it asserts the winner's grant for that cycle, drives start_write=0 (we=1) or start_read=0 (we=0), then goes to WAIT_BUSY.
REQ-025 Latency SHALL be: request sampled in IDLE at cycle N gives grant and start low at cycle N+1.
REQ-026 The start strobe SHALL stay low through WAIT_BUSY until process_flg=1 is sampled, so that the slower driver clock domain cannot miss it; at that point the strobe returns high and the FSM goes to WAIT_IDLE.
REQ-027 WAIT_IDLE SHALL wait for process_flg=0, then pulse the owner's done for 1 cycle, update last_served and return to IDLE.
REQ-028 Only one of start_write and start_read SHALL be low at any time, and both SHALL be high outside ISSUE and WAIT_BUSY.
REQ-029 A timeout counter SHALL clear on entry to WAIT_BUSY and to WAIT_IDLE and increment each cycle in those states.
REQ-030 When the timeout counter reaches TIMEOUT, the block SHALL set timeout_err=1, release the start strobe, pulse the owner's done and return to IDLE.
REQ-031 timeout_err SHALL clear only on reset.
REQ-032 The refresh counter SHALL be a free-running 0..REFRESH_INTERVAL-1 counter that wraps to 0.
REQ-033 refresh_due SHALL be 1 while count >= REFRESH_INTERVAL-GUARD.
REQ-034 refresh_due SHALL gate only new grants; a transaction already in flight SHALL complete.
REQ-035 A requester SHALL hold req until it is granted; dropping req before grant withdraws the request with no side effect.
REQ-036 After grant, the owner's req, we, addr and bank inputs SHALL be ignored until its done pulse.
REQ-037 A request arriving while not in IDLE SHALL wait; it SHALL never be granted in the same cycle as another requester's done pulse.
REQ-038 A counter width SHALL be clog2 of its parameter value plus 1.

Reset
REQ-039 On reset=1 at a clock edge, the block SHALL set: state=IDLE, a_grant=b_grant=a_done=b_done=0, start_write=start_read=1, ADDR=0, BANK=0, refresh counter=0, refresh_due=0, timeout counter=0, timeout_err=0, last_served=B.
REQ-040 Reset asserted mid-transaction SHALL abort the transaction without issuing a done pulse, and the strobes SHALL be high in the next cycle.

Verification (bench parameters: REFRESH_INTERVAL=64, GUARD=8, TIMEOUT=16)
REQ-041 Single write: a_req=1, a_we=1, a_addr=0x155, a_bank=2, model busy for 5 cycles -> a_grant at N+1, start_write low until busy is seen, ADDR=0x155, BANK=2, a_done 1 cycle after busy drops.
REQ-042 Tie: a_req=b_req=1 from reset -> A served first, then B, then A; no overlap of grants or strobes.
REQ-043 Refresh window: request raised at refresh count 57 -> no grant until count wraps to 0; grant at count 0 (+1 cycle).
REQ-044 Timeout: driver model never raises process_flg -> after 16 WAIT_BUSY cycles start_read returns high, done pulses, timeout_err=1 and stays 1.
REQ-045 Reset mid-transaction in WAIT_IDLE -> next cycle all outputs at reset values, no done pulse.
REQ-046 Withdrawal: b_req pulsed for 1 cycle while A is busy -> B is never granted.
